// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forward selects, result-source codes.
package pipe_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle; master is the controller, slave is the datapath side.
interface hazard_ctrl_if #(parameter int unsigned CNT_W = 32);
    import pipe_pkg::*;

    logic [REG_W-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0]       result_srcE;
    logic             reg_write_enM, reg_write_enW;
    logic             pc_srcE, mem_accessM, dmem_ready;
    logic             dmem_req;
    logic [1:0]       forward_aE, forward_bE;
    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushW;
    logic             mem_err;
    logic [CNT_W-1:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;

    modport master (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, result_srcE,
               reg_write_enM, reg_write_enW, pc_srcE, mem_accessM, dmem_ready,
        output dmem_req, forward_aE, forward_bE, stallF, stallD, stallE, stallM,
               flushD, flushE, flushW, mem_err, lu_stall_cnt, mem_stall_cnt, flush_cnt
    );

    modport slave (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, result_srcE,
               reg_write_enM, reg_write_enW, pc_srcE, mem_accessM, dmem_ready,
        input  dmem_req, forward_aE, forward_bE, stallF, stallD, stallE, stallM,
               flushD, flushE, flushW, mem_err, lu_stall_cnt, mem_stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fwd_unit.sv
// Operand forwarding select for one E-stage source register; M result beats W result.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             we_m,
    input  logic             we_w,
    output logic [1:0]       sel
);

    always_comb begin
        sel = FWD_RF;
        if (we_m && (rd_m != '0) && (rd_m == rs))
            sel = FWD_M;
        else if (we_w && (rd_w != '0) && (rd_w == rs))
            sel = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forward controller with data-memory wait FSM and timeout error.
// Optional PERF_CNT_EN builds saturating stall/flush cycle counters; otherwise they read 0.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.master hz
);

    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            req, mem_stall, lw_stall;

    fwd_unit u_fwd_a (
        .rs   (hz.rs1E),
        .rd_m (hz.rdM),
        .rd_w (hz.rdW),
        .we_m (hz.reg_write_enM),
        .we_w (hz.reg_write_enW),
        .sel  (hz.forward_aE)
    );

    fwd_unit u_fwd_b (
        .rs   (hz.rs2E),
        .rd_m (hz.rdM),
        .rd_w (hz.rdW),
        .we_m (hz.reg_write_enM),
        .we_w (hz.reg_write_enW),
        .sel  (hz.forward_bE)
    );

    assign lw_stall = (hz.result_srcE == RESULT_SRC_LOAD) && (hz.rdE != '0) &&
                      ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A miss in IDLE already stalls; WAIT releases the stall in the cycle ready arrives.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req       = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req = hz.mem_accessM;
                if (hz.mem_accessM && !hz.dmem_ready) begin
                    mem_stall = 1'b1;
                    state_d   = ST_WAIT;
                    cnt_d     = '0;
                end
            end
            ST_WAIT: begin
                req       = 1'b1;
                mem_stall = !hz.dmem_ready;
                if (hz.dmem_ready)
                    state_d = ST_IDLE;
                else if (cnt_q == TW'(MEM_TIMEOUT - 1))
                    state_d = ST_ERR;
                else
                    cnt_d = cnt_q + TW'(1);
            end
            ST_ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Everything except forwarding is held low while reset is asserted.
    assign hz.dmem_req = reset & req;
    assign hz.stallF   = reset & (mem_stall | lw_stall);
    assign hz.stallD   = reset & (mem_stall | lw_stall);
    assign hz.stallE   = reset & mem_stall;
    assign hz.stallM   = reset & mem_stall;
    assign hz.flushW   = reset & mem_stall;
    assign hz.flushD   = reset & !mem_stall & hz.pc_srcE;
    assign hz.flushE   = reset & !mem_stall & (lw_stall | hz.pc_srcE);
    assign hz.mem_err  = (state_q == ST_ERR);

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] lu_q, ms_q, fl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lu_q <= '0;
            ms_q <= '0;
            fl_q <= '0;
        end else begin
            if (lw_stall && !mem_stall && (lu_q != '1))
                lu_q <= lu_q + CNT_W'(1);
            if (mem_stall && (ms_q != '1))
                ms_q <= ms_q + CNT_W'(1);
            if (hz.pc_srcE && !mem_stall && (fl_q != '1))
                fl_q <= fl_q + CNT_W'(1);
        end
    end

    assign hz.lu_stall_cnt  = lu_q;
    assign hz.mem_stall_cnt = ms_q;
    assign hz.flush_cnt     = fl_q;
`else
    assign hz.lu_stall_cnt  = CNT_W'(0);
    assign hz.mem_stall_cnt = CNT_W'(0);
    assign hz.flush_cnt     = CNT_W'(0);
`endif

endmodule
